// File: rtl/qmax_writer.sv
// qmax_writer: update-side controller for the per-state Q-max table.
// Each accepted (state, q) request is read in the accept cycle, compared in the
// next cycle, and written back only if q is strictly larger than the stored value.
// A clear sequence writes zero to every entry, one address per cycle.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid, i_state, i_q        update request; accepted when i_valid && o_ready
//   o_ready                      request can be accepted this cycle
//   i_clear                      pulse that starts the table clear
//   o_busy, o_clear_done         clear in progress / last clear write issued
//   o_updated, o_upd_count       request caused a write / wrapping write counter
//   o_tbl_addr_r, o_tbl_read_en  table read port (data returns next cycle on i_tbl_data)
//   o_tbl_addr_w, o_tbl_write_en,
//   o_tbl_data                   table write port
module qmax_writer #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_state,
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic                  o_ready,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clear_done,
    output logic                  o_updated,
    output logic [CNT_WIDTH-1:0]  o_upd_count,
    output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
    output logic                  o_tbl_read_en,
    input  logic [DATA_WIDTH-1:0] i_tbl_data,
    output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
    output logic                  o_tbl_write_en,
    output logic [DATA_WIDTH-1:0] o_tbl_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_nxt;

    logic                    s1_valid;
    logic [ADDR_WIDTH-1:0]   s1_state;
    logic [DATA_WIDTH-1:0]   s1_q;

    logic                    fwd_valid;
    logic [ADDR_WIDTH-1:0]   fwd_addr;
    logic [DATA_WIDTH-1:0]   fwd_data;

    logic [CNT_WIDTH-1:0]    upd_count;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   cur;

    assign o_upd_count = upd_count;

    // Registers: FSM state, clear address, S1 stage, forwarding register, counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= RUN;
            clr_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_state  <= '0;
            s1_q      <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            upd_count <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
            s1_valid <= accept;
            if (accept) begin
                s1_state <= i_state;
                s1_q     <= i_q;
            end
            // Table reads return pre-write data on a same-edge collision; remember the last write.
            fwd_valid <= o_tbl_write_en;
            if (o_tbl_write_en) begin
                fwd_addr <= o_tbl_addr_w;
                fwd_data <= o_tbl_data;
            end
            if (o_updated) begin
                upd_count <= upd_count + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and table-port control.
    always_comb begin
        state_nxt      = state;
        clr_addr_nxt   = clr_addr;
        accept         = 1'b0;
        o_ready        = 1'b0;
        o_busy         = 1'b0;
        o_clear_done   = 1'b0;
        o_updated      = 1'b0;
        o_tbl_read_en  = 1'b0;
        o_tbl_addr_r   = '0;
        o_tbl_write_en = 1'b0;
        o_tbl_addr_w   = '0;
        o_tbl_data     = '0;
        cur            = (fwd_valid && (fwd_addr == s1_state)) ? fwd_data : i_tbl_data;

        case (state)
            RUN: begin
                o_ready = !i_rst && !i_clear;
                accept  = o_ready && i_valid;
                if (accept) begin
                    o_tbl_read_en = 1'b1;
                    o_tbl_addr_r  = i_state;
                end
                // S1 always completes, even in the cycle the clear is requested.
                if (s1_valid && (s1_q > cur)) begin
                    o_tbl_write_en = 1'b1;
                    o_tbl_addr_w   = s1_state;
                    o_tbl_data     = s1_q;
                    o_updated      = 1'b1;
                end
                if (i_clear) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            CLEAR: begin
                o_busy         = 1'b1;
                o_tbl_write_en = 1'b1;
                o_tbl_addr_w   = clr_addr;
                if (clr_addr == LAST_ADDR) begin
                    o_clear_done = 1'b1;
                    state_nxt    = RUN;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_qmax_writer.sv
// Testbench for qmax_writer: table memory model, scoreboard of expected writes,
// and a monitor that checks every table write the DUT issues.
module tb_qmax_writer;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
        logic       upd;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, clr;
    logic [5:0]  st;
    logic [7:0]  q;
    logic        ready, busy, done, updated;
    logic [15:0] cnt;
    logic [5:0]  addr_r, addr_w;
    logic        rd_en, wr_en;
    logic [7:0]  rdata, wdata;

    // Second instance with a 4-bit counter for the wrap test.
    logic        v4, clr4;
    logic [5:0]  s4;
    logic [7:0]  q4;
    logic        ready4, busy4, done4, updated4;
    logic [3:0]  cnt4;
    logic [5:0]  addr_r4, addr_w4;
    logic        rd_en4, wr_en4;
    logic [7:0]  rdata4, wdata4;

    logic [7:0]  mem  [64] = '{default: 8'h00};
    logic [7:0]  mem4 [64] = '{default: 8'h00};

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          writes4  = 0;

    always #5 clk = ~clk;

    qmax_writer u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_state(st), .i_q(q),
        .o_ready(ready), .i_clear(clr), .o_busy(busy), .o_clear_done(done),
        .o_updated(updated), .o_upd_count(cnt), .o_tbl_addr_r(addr_r),
        .o_tbl_read_en(rd_en), .i_tbl_data(rdata), .o_tbl_addr_w(addr_w),
        .o_tbl_write_en(wr_en), .o_tbl_data(wdata)
    );

    qmax_writer #(.CNT_WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_state(s4), .i_q(q4),
        .o_ready(ready4), .i_clear(clr4), .o_busy(busy4), .o_clear_done(done4),
        .o_updated(updated4), .o_upd_count(cnt4), .o_tbl_addr_r(addr_r4),
        .o_tbl_read_en(rd_en4), .i_tbl_data(rdata4), .o_tbl_addr_w(addr_w4),
        .o_tbl_write_en(wr_en4), .o_tbl_data(wdata4)
    );

    // Synchronous table: one-cycle read latency, read returns old data on collision.
    always @(posedge clk) begin
        if (rd_en)  rdata <= mem[addr_r];
        if (wr_en)  mem[addr_w] <= wdata;
        if (rd_en4) rdata4 <= mem4[addr_r4];
        if (wr_en4) mem4[addr_w4] <= wdata4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] s, input logic [7:0] d, input logic c);
        @(posedge clk);
        #1;
        valid = v;
        st    = s;
        q     = d;
        clr   = c;
    endtask

    task automatic push(input logic [5:0] a, input logic [7:0] d, input logic u, input logic dn);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.upd  = u;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    // Monitor: every table write must match the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {26'd0, addr_w}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {26'd0, addr_w}, {26'd0, e.addr});
                    chk("wr_data", {24'd0, wdata}, {24'd0, e.data});
                    chk("wr_updated", {31'd0, updated}, {31'd0, e.upd});
                    chk("wr_clear_done", {31'd0, done}, {31'd0, e.done});
                end
            end else if (updated || done) begin
                chk("pulse_without_write", {30'd0, updated, done}, 32'd0);
            end
        end
        if (!rst && wr_en4) writes4++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bit found;
        rst = 1'b1; valid = 1'b0; clr = 1'b0; st = '0; q = '0;
        v4 = 1'b0; clr4 = 1'b0; s4 = '0; q4 = '0;
        #3;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_count", {16'd0, cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // New entry written, smaller follow-up not written.
        push(6'd5, 8'h10, 1'b1, 1'b0);
        drive(1'b1, 6'd5, 8'h10, 1'b0);
        #1 chk("ready_run", {31'd0, ready}, 32'd1);
        drive(1'b1, 6'd5, 8'h08, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("count_t1", {16'd0, cnt}, 32'd1);

        // Back-to-back same address through the forwarding path.
        push(6'd3, 8'h20, 1'b1, 1'b0);
        push(6'd3, 8'h30, 1'b1, 1'b0);
        drive(1'b1, 6'd3, 8'h20, 1'b0);
        drive(1'b1, 6'd3, 8'h30, 1'b0);
        drive(1'b1, 6'd3, 8'h25, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("count_t2", {16'd0, cnt}, 32'd3);
        chk("entry3", {24'd0, mem[3]}, 32'h30);

        // Equal value produces no write.
        push(6'd7, 8'h40, 1'b1, 1'b0);
        drive(1'b1, 6'd7, 8'h40, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b1, 6'd7, 8'h40, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("count_t3", {16'd0, cnt}, 32'd4);

        // Clear with a pending S1 write; simultaneous request is refused.
        push(6'd9, 8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) push(6'(i), 8'h00, 1'b0, (i == 63));
        drive(1'b1, 6'd9, 8'h50, 1'b0);
        drive(1'b1, 6'd10, 8'h77, 1'b1);
        #1 chk("ready_on_clear", {31'd0, ready}, 32'd0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        #1 chk("busy_clear", {31'd0, busy}, 32'd1);
        chk("ready_in_clear", {31'd0, ready}, 32'd0);
        repeat (10) drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b1);   // ignored while clearing
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("clear_done_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        chk("ready_after_clear", {31'd0, ready}, 32'd1);
        chk("busy_after_clear", {31'd0, busy}, 32'd0);
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] != 8'h00) nz++;
        chk("nonzero_after_clear", 32'(nz), 32'd0);
        chk("count_t4", {16'd0, cnt}, 32'd5);

        // Reset during clear at address 20.
        for (int i = 0; i <= 20; i++) push(6'(i), 8'h00, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b1);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_en && busy && addr_w == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        chk("clear_addr20_seen", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_mid_addr_w", {26'd0, addr_w}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_count", {16'd0, cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        push(6'd40, 8'h01, 1'b1, 1'b0);
        drive(1'b1, 6'd40, 8'h01, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        drive(1'b0, 6'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("count_after_rst", {16'd0, cnt}, 32'd1);
        chk("entry40", {24'd0, mem[40]}, 32'h01);

        // Counter wrap on the 4-bit instance: 17 writes.
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1 v4 = 1'b1; s4 = 6'd1; q4 = 8'(k);
        end
        @(posedge clk);
        #1 v4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("cnt4_wrap", {28'd0, cnt4}, 32'd1);
        chk("writes4", 32'(writes4), 32'd17);
        chk("entry4_1", {24'd0, mem4[1]}, 32'd17);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
